// File: rtl/switch_allocator_pkg.sv
// Shared NoC router parameters: default port counts, port-index typedefs and
// the round-robin pointer wrap helper.
package noc_params;

  localparam int NOC_INPUT_NUM  = 4;
  localparam int NOC_OUTPUT_NUM = 4;
  localparam int NOC_SEL_SIZE   = (NOC_INPUT_NUM > 1) ? $clog2(NOC_INPUT_NUM) : 1;
  localparam int NOC_OUT_SIZE   = (NOC_OUTPUT_NUM > 1) ? $clog2(NOC_OUTPUT_NUM) : 1;

  typedef logic [NOC_SEL_SIZE-1:0] port_sel_t;
  typedef logic [NOC_OUT_SIZE-1:0] out_port_t;

  function automatic int next_idx(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/switch_allocator_if.sv
// Allocator request/grant bundle. The master (input-port side) drives requests;
// the slave (allocator) returns grants and crossbar selects.
interface switch_allocator_if
  import noc_params::*;
#(
  parameter int INPUT_NUM  = NOC_INPUT_NUM,
  parameter int OUTPUT_NUM = NOC_OUTPUT_NUM
);
  localparam int SEL_SIZE = (INPUT_NUM > 1) ? $clog2(INPUT_NUM) : 1;
  localparam int OUT_SIZE = (OUTPUT_NUM > 1) ? $clog2(OUTPUT_NUM) : 1;

  logic [INPUT_NUM-1:0]                 request_i;
  logic [INPUT_NUM-1:0][OUT_SIZE-1:0]   out_port_i;
  logic [INPUT_NUM-1:0]                 tail_i;
  logic [OUTPUT_NUM-1:0]                out_ready_i;
  logic [INPUT_NUM-1:0]                 grant_o;
  logic [OUTPUT_NUM-1:0][SEL_SIZE-1:0]  sel_o;
  logic [OUTPUT_NUM-1:0]                valid_o;

  modport master (output request_i, out_port_i, tail_i, out_ready_i,
                  input  grant_o, sel_o, valid_o);
  modport slave  (input  request_i, out_port_i, tail_i, out_ready_i,
                  output grant_o, sel_o, valid_o);
endinterface

// File: rtl/switch_allocator_round_robin_arbiter.sv
// Single-output round-robin arbiter with optional wormhole lock; holds the
// priority pointer and lock owner for one router output.
module round_robin_arbiter
  import noc_params::*;
#(
  parameter int N = NOC_INPUT_NUM,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         ready,
  input  logic         lock_en,
  input  logic         tail,
  output logic [N-1:0] grant,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_valid,
  output logic         locked_o,
  output logic [W-1:0] owner_o
);
  logic [W-1:0] ptr_q, ptr_d, owner_q, owner_d;
  logic         locked_q, locked_d;
  logic         found;
  logic [W-1:0] win;

  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    if (locked_q) begin
      found = req[owner_q];
      win   = owner_q;
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = (int'(ptr_q) + k) % N;
        if (!found && req[idx]) begin
          found = 1'b1;
          win   = W'(idx);
        end
      end
    end
    gnt_valid = found && ready && !rst;
    gnt_idx   = gnt_valid ? win : '0;
    grant     = '0;
    if (gnt_valid) grant[win] = 1'b1;
  end

  // Kept apart from the grant logic: tail arrives from the top via gnt_idx.
  always_comb begin
    ptr_d    = ptr_q;
    locked_d = locked_q;
    owner_d  = owner_q;
    if (gnt_valid) begin
      if (lock_en && !tail) begin
        locked_d = 1'b1;
        owner_d  = gnt_idx;
      end else begin
        locked_d = 1'b0;
        ptr_d    = W'(next_idx(int'(gnt_idx), N));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q    <= '0;
      locked_q <= 1'b0;
      owner_q  <= '0;
    end else begin
      ptr_q    <= ptr_d;
      locked_q <= locked_d;
      owner_q  <= owner_d;
    end
  end

  assign locked_o = locked_q;
  assign owner_o  = owner_q;
endmodule

// File: rtl/switch_allocator.sv
// Per-output round-robin switch allocator driving the crossbar selects.
// Wormhole locking is built in when SWITCH_ALLOCATOR_WORMHOLE_LOCK_EN is defined.
module switch_allocator
  import noc_params::*;
#(
  parameter int INPUT_NUM  = NOC_INPUT_NUM,
  parameter int OUTPUT_NUM = NOC_OUTPUT_NUM
) (
  input logic               clk,
  input logic               rst,
  switch_allocator_if.slave bus
);
  localparam int SEL_SIZE = (INPUT_NUM > 1) ? $clog2(INPUT_NUM) : 1;
  localparam int OUT_SIZE = (OUTPUT_NUM > 1) ? $clog2(OUTPUT_NUM) : 1;

`ifdef SWITCH_ALLOCATOR_WORMHOLE_LOCK_EN
  localparam logic LOCK_EN = 1'b1;
`else
  localparam logic LOCK_EN = 1'b0;
`endif

  logic [OUTPUT_NUM-1:0][INPUT_NUM-1:0] arb_req, arb_grant;
  logic [OUTPUT_NUM-1:0]                arb_valid, arb_locked, arb_tail;
  logic [OUTPUT_NUM-1:0][SEL_SIZE-1:0]  arb_idx, arb_owner;
  logic [INPUT_NUM-1:0]                 lock_busy;

  always_comb begin
    lock_busy = '0;
    for (int o = 0; o < OUTPUT_NUM; o++)
      for (int i = 0; i < INPUT_NUM; i++)
        if (arb_locked[o] && arb_owner[o] == SEL_SIZE'(i)) lock_busy[i] = 1'b1;
  end

  // A lock owner may only compete at the output it holds.
  always_comb begin
    arb_req = '0;
    for (int o = 0; o < OUTPUT_NUM; o++)
      for (int i = 0; i < INPUT_NUM; i++)
        arb_req[o][i] = bus.request_i[i] && (bus.out_port_i[i] == OUT_SIZE'(o)) &&
                        (!lock_busy[i] || (arb_locked[o] && arb_owner[o] == SEL_SIZE'(i)));
  end

  always_comb begin
    arb_tail = '0;
    for (int o = 0; o < OUTPUT_NUM; o++) arb_tail[o] = bus.tail_i[arb_idx[o]];
  end

  for (genvar o = 0; o < OUTPUT_NUM; o++) begin : g_out
    round_robin_arbiter #(.N(INPUT_NUM)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (arb_req[o]),
      .ready     (bus.out_ready_i[o]),
      .lock_en   (LOCK_EN),
      .tail      (arb_tail[o]),
      .grant     (arb_grant[o]),
      .gnt_idx   (arb_idx[o]),
      .gnt_valid (arb_valid[o]),
      .locked_o  (arb_locked[o]),
      .owner_o   (arb_owner[o])
    );
  end

  always_comb begin
    bus.grant_o = '0;
    for (int o = 0; o < OUTPUT_NUM; o++) bus.grant_o = bus.grant_o | arb_grant[o];
  end

  assign bus.sel_o   = arb_idx;
  assign bus.valid_o = arb_valid;
endmodule

// File: tb/tb_switch_allocator.sv
// Bench for switch_allocator: directed vectors with literal expectations plus a
// per-cycle comparison against a queue-free behavioural allocation model.
module tb_switch_allocator;
  localparam int NI = 4;
  localparam int NO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  switch_allocator_if #(.INPUT_NUM(NI), .OUTPUT_NUM(NO)) bus ();
  switch_allocator #(.INPUT_NUM(NI), .OUTPUT_NUM(NO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

`ifdef SWITCH_ALLOCATOR_WORMHOLE_LOCK_EN
  localparam bit LOCK_MODE = 1'b1;
`else
  localparam bit LOCK_MODE = 1'b0;
`endif

  int m_ptr   [NO] = '{default: 0};
  bit m_lock  [NO] = '{default: 0};
  int m_owner [NO] = '{default: 0};

  function automatic bit owns_lock(input int i);
    for (int o = 0; o < NO; o++) if (m_lock[o] && m_owner[o] == i) return 1'b1;
    return 1'b0;
  endfunction

  // Model: who wins each output this cycle, then advance the bookkeeping.
  always @(negedge clk) begin
    int w [NO];
    int cand;
    logic [NI-1:0]  eg;
    logic [NO-1:0]  ev;
    logic [7:0]     es;
    eg = '0; ev = '0; es = '0;
    for (int o = 0; o < NO; o++) w[o] = -1;
    if (rst) begin
      for (int o = 0; o < NO; o++) begin m_ptr[o] = 0; m_lock[o] = 0; m_owner[o] = 0; end
    end else begin
      for (int o = 0; o < NO; o++) begin
        if (m_lock[o]) begin
          if (bus.request_i[m_owner[o]] && int'(bus.out_port_i[m_owner[o]]) == o)
            w[o] = m_owner[o];
        end else begin
          for (int k = 0; k < NI; k++) begin
            cand = (m_ptr[o] + k) % NI;
            if (w[o] < 0 && bus.request_i[cand] && int'(bus.out_port_i[cand]) == o &&
                !owns_lock(cand))
              w[o] = cand;
          end
        end
        if (!bus.out_ready_i[o]) w[o] = -1;
      end
      for (int o = 0; o < NO; o++) begin
        if (w[o] >= 0) begin
          eg[w[o]] = 1'b1;
          ev[o] = 1'b1;
          es[o*2 +: 2] = 2'(w[o]);
          if (LOCK_MODE && !bus.tail_i[w[o]]) begin
            m_lock[o] = 1'b1;
            m_owner[o] = w[o];
          end else begin
            m_lock[o] = 1'b0;
            m_ptr[o] = (w[o] + 1) % NI;
          end
        end
      end
    end
    checks++;
    if (bus.grant_o !== eg) begin
      errors++;
      $display("FAIL model_grant t=%0t got=%b exp=%b", $time, bus.grant_o, eg);
    end
    checks++;
    if (bus.valid_o !== ev) begin
      errors++;
      $display("FAIL model_valid t=%0t got=%b exp=%b", $time, bus.valid_o, ev);
    end
    checks++;
    if (bus.sel_o !== es) begin
      errors++;
      $display("FAIL model_sel t=%0t got=%h exp=%h", $time, bus.sel_o, es);
    end
  end

  task automatic cyc(input logic r, input logic [3:0] rq, input logic [7:0] pt,
                     input logic [3:0] tl, input logic [3:0] rd);
    rst = r;
    bus.request_i = rq;
    bus.out_port_i = pt;
    bus.tail_i = tl;
    bus.out_ready_i = rd;
    #3;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [3:0] g, input logic [3:0] v,
                     input logic [7:0] s);
    checks++;
    if (bus.grant_o !== g || bus.valid_o !== v || bus.sel_o !== s) begin
      errors++;
      $display("FAIL %s got grant=%b valid=%b sel=%h exp grant=%b valid=%b sel=%h",
               name, bus.grant_o, bus.valid_o, bus.sel_o, g, v, s);
    end
  endtask

  initial begin
    logic [7:0] rp;
    // Reset with everything requesting output 2
    cyc(1, 4'hF, 8'hAA, 4'hF, 4'hF); lit("reset_hold", 4'h0, 4'h0, 8'h00); tick();
    cyc(1, 4'hF, 8'hAA, 4'hF, 4'hF); lit("reset_hold2", 4'h0, 4'h0, 8'h00); tick();

    // Round robin at output 2: 0,1,2,3,0
    for (int n = 0; n < 5; n++) begin
      cyc(0, 4'hF, 8'hAA, 4'hF, 4'hF);
      lit("round_robin", 4'(1 << (n % 4)), 4'b0100, 8'((n % 4) << 4));
      tick();
    end

    // Wormhole at output 0: input 1 packet against input 3 single flits
    cyc(0, 4'b1010, 8'h00, 4'b1000, 4'hF);
`ifdef SWITCH_ALLOCATOR_WORMHOLE_LOCK_EN
    lit("wh_head", 4'b0010, 4'b0001, 8'h01);
`endif
    tick();
    cyc(0, 4'b1010, 8'h00, 4'b1000, 4'hF);
`ifdef SWITCH_ALLOCATOR_WORMHOLE_LOCK_EN
    lit("wh_body", 4'b0010, 4'b0001, 8'h01);
`endif
    tick();
    cyc(0, 4'b1010, 8'h00, 4'b1000, 4'b1110);
    lit("backpressure1", 4'b0000, 4'b0000, 8'h00); tick();
    cyc(0, 4'b1010, 8'h00, 4'b1000, 4'b1110);
    lit("backpressure2", 4'b0000, 4'b0000, 8'h00); tick();
    cyc(0, 4'b1000, 8'h00, 4'b1000, 4'hF);
`ifdef SWITCH_ALLOCATOR_WORMHOLE_LOCK_EN
    lit("bubble_hold", 4'b0000, 4'b0000, 8'h00);
`endif
    tick();
    cyc(0, 4'b1010, 8'h0C, 4'b1010, 4'hF);
`ifdef SWITCH_ALLOCATOR_WORMHOLE_LOCK_EN
    lit("owner_elsewhere", 4'b0000, 4'b0000, 8'h00);
`endif
    tick();
    cyc(0, 4'b1010, 8'h00, 4'b1010, 4'hF);
`ifdef SWITCH_ALLOCATOR_WORMHOLE_LOCK_EN
    lit("wh_tail", 4'b0010, 4'b0001, 8'h01);
`endif
    tick();
    cyc(0, 4'b1000, 8'h00, 4'b1000, 4'hF);
    lit("wh_after", 4'b1000, 4'b0001, 8'h03); tick();

    // All four inputs to distinct outputs
    cyc(0, 4'hF, 8'h1B, 4'hF, 4'hF);
    lit("parallel", 4'hF, 4'hF, 8'h1B); tick();

    // Reset in the middle of input 2's packet at output 1
    cyc(0, 4'b0100, 8'h10, 4'b0000, 4'hF);
    lit("mid_head", 4'b0100, 4'b0010, 8'h08); tick();
    cyc(1, 4'b0101, 8'h11, 4'b0001, 4'hF);
    lit("mid_reset", 4'b0000, 4'b0000, 8'h00); tick();
    cyc(0, 4'b0101, 8'h11, 4'b0001, 4'hF);
    lit("after_reset", 4'b0001, 4'b0010, 8'h00); tick();

    // Mixed traffic checked by the model alone
    for (int n = 0; n < 80; n++) begin
      rp = 8'($urandom);
      cyc(0, 4'($urandom), rp, 4'($urandom_range(0, 15) | ((n % 3 == 0) ? 4'hF : 4'h0)),
          4'($urandom_range(0, 15) | 4'b0101));
      tick();
    end

    cyc(0, 4'h0, 8'h00, 4'h0, 4'hF);
    lit("idle", 4'h0, 4'h0, 8'h00); tick();

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
